muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
// Iterative multiply/divide unit for the pipelined MIPS core's EX stage (MULT, MULTU, DIV, DIVU).
// Generalised to WIDTH-bit operands. Produces a HI/LO result pair after a fixed, data-independent latency.
// busy_o feeds the hazard-detection stall path, which holds IF/ID and the PC until the result is available.
// PARAMETERS
// WIDTH   32   operand width; HI and LO are each WIDTH bits; >= 4, even
// PORTS
// clk_i       in   1      clock, rising edge
// rst_i       in   1      reset, asynchronous, active-low (0 = reset)
// op_valid_i  in   1      issue request; sampled only in IDLE
// op_i        in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
// a_i         in   WIDTH  multiplicand / dividend (rs)
// b_i         in   WIDTH  multiplier / divisor (rt)
// flush_i     in   1      abort current operation (branch/jump flush)
// busy_o      out  1      operation in flight; stall request to hazard unit
// done_o      out  1      one-cycle pulse: hi_o/lo_o just updated
// hi_o        out  WIDTH  MUL: upper product half; DIV: remainder
// lo_o        out  WIDTH  MUL: lower product half; DIV: quotient
// BEHAVIOUR
// - Reset (rst_i=0, any time, async): state=IDLE; busy_o=0; done_o=0; hi_o=0; lo_o=0; counter=0.
// - States:
//   - IDLE: op_valid_i=1 and flush_i=0 at edge E0 latches op, operand magnitudes and sign bits; goes to CALC.
//   - CALC: one iteration per edge for WIDTH edges (E1..E_WIDTH).
//     - Multiply: radix-2 shift-add.
//     - Divide: restoring shift-subtract.
//   - FIX: at edge E_WIDTH+1, applies sign correction and writes hi_o/lo_o; goes to IDLE.
// - Latency: busy_o=1 in cycles after E0 through E_WIDTH. done_o=1 only in the cycle after E_WIDTH+1 (busy_o=0 then).
// - Back-to-back: a new op may be accepted in the done_o cycle.
// - op_valid_i while busy_o=1: ignored; the in-flight op is not disturbed.
// - Signed ops: operate on magnitudes.
//   - MULT: negate the 2*WIDTH product if sign(a)^sign(b).
//   - DIV: quotient sign = sign(a)^sign(b); remainder sign = sign(a).
// - Divide by zero: latency unchanged; lo_o = all ones; hi_o = a_i as issued (both signed and unsigned).
// - Signed overflow (DIV MIN / -1): lo_o = MIN, hi_o = 0 (natural wrap, no trap).
// - Widths: product and remainder internals are 2*WIDTH bits; counter is clog2(WIDTH)+1 bits.
//   - All arithmetic is modulo 2^WIDTH per half.
// - flush_i=1 in CALC or FIX: returns to IDLE at the next edge.
//   - No done_o; hi_o/lo_o keep their previous values; busy_o=0 in the following cycle.
// - flush_i=1 in IDLE together with op_valid_i: flush wins, op not accepted.
// - hi_o/lo_o change only in FIX (or reset); they hold indefinitely otherwise.
// TESTING (WIDTH=32)
// - MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE lo=00000001; done_o exactly 34 cycles after accept edge; busy_o high 33 cycles.
// - MULT -3*5 -> hi=FFFFFFFF lo=FFFFFFF1; DIV -7/2 -> lo=FFFFFFFD hi=FFFFFFFF; DIVU 100/7 -> lo=0000000E hi=00000002.
// - DIVU 7/0 -> lo=FFFFFFFF hi=00000007, same latency; DIV 80000000/FFFFFFFF -> lo=80000000 hi=00000000.
// - Issue MULT, pulse op_valid_i with different operands at cycle 5 -> first result unchanged; second op never runs.
// - flush_i at cycle 10 of a DIV -> no done_o, hi/lo hold prior result, busy_o=0 next cycle; then a new op completes normally.
// - rst_i low mid-CALC -> busy_o, done_o, hi_o, lo_o = 0 immediately (async); op_valid_i held across release is accepted at first edge.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with fixed latency
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             op_valid_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Latched operation: op_i[1] selects divide, op_i[0] selects signed.
    logic             is_div;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_mag;
    logic [CW-1:0]    count;

    // Shared 2*WIDTH working register: multiplier/product for MUL,
    // {partial remainder, dividend/quotient} for DIV.
    logic [2*WIDTH-1:0] acc;

    logic             accept;
    logic             last_iter;
    logic             in_signed;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_upper;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    assign accept    = op_valid_i && !flush_i;
    assign last_iter = (count == CW'(WIDTH - 1));
    assign busy_o    = (state != S_IDLE);

    // Magnitudes of the issuing operands; unsigned ops pass straight through.
    assign in_signed = op_i[0];
    assign a_mag_in  = (in_signed && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
    assign b_mag_in  = (in_signed && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a flush anywhere outside IDLE abandons the operation.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_next = S_IDLE;
                end else if (last_iter) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // One shift-add (multiply) and one restoring shift-subtract (divide) step.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_mag : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_upper = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_upper >= {1'b0, b_mag});
        div_diff  = div_upper - {1'b0, b_mag};
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_upper[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ge};
    end

    // Sign correction and divide-by-zero override for the final write.
    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
        q_mag    = acc[WIDTH-1:0];
        r_mag    = acc[2*WIDTH-1:WIDTH];
        hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_mag == {WIDTH{1'b0}}) begin
                hi_fix = a_raw;
                lo_fix = {WIDTH{1'b1}};
            end else begin
                hi_fix = neg_a ? (~r_mag + 1'b1) : r_mag;
                lo_fix = (neg_a ^ neg_b) ? (~q_mag + 1'b1) : q_mag;
            end
        end
    end

    // Operand capture, iteration and result write; hi/lo move only in FIX.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            a_raw  <= '0;
            b_mag  <= '0;
            count  <= '0;
            acc    <= '0;
            done_o <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_div <= op_i[1];
                        neg_a  <= in_signed && a_i[WIDTH-1];
                        neg_b  <= in_signed && b_i[WIDTH-1];
                        a_raw  <= a_i;
                        b_mag  <= b_mag_in;
                        count  <= '0;
                        acc    <= {{WIDTH{1'b0}}, a_mag_in};
                    end
                end
                S_CALC: begin
                    if (!flush_i) begin
                        acc   <= is_div ? div_next : mul_next;
                        count <= count + CW'(1);
                    end
                end
                S_FIX: begin
                    if (!flush_i) begin
                        hi_o   <= hi_fix;
                        lo_o   <= lo_fix;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         op_valid_i;
    logic [1:0]   op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         flush_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int n_pass  = 0;
    int n_total = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .op_valid_i (op_valid_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        case (op)
            2'b00: p = {32'b0, a} * {32'b0, b};
            2'b01: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    p = {a % b, a / b};
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    p = {32'h0, 32'h8000_0000};
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p = {sr, sq};
                end
            end
        endcase
        return p;
    endfunction

    // Latency model: result lands W+1 edges after the accept edge unless flushed.
    int          m_rem;
    logic [63:0] m_pend;
    logic        m_done;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (op_valid_i && !flush_i) begin
                    m_rem  <= W + 1;
                    m_pend <= ref_result(op_i, a_i, b_i);
                end
            end else if (flush_i) begin
                m_rem <= 0;
            end else if (m_rem == 1) begin
                m_hi   <= m_pend[63:32];
                m_lo   <= m_pend[31:0];
                m_done <= 1'b1;
                m_rem  <= 0;
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk_i) begin
        check("cycle", {busy_o, done_o, hi_o, lo_o}, {(m_rem != 0), m_done, m_hi, m_lo});
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op (now=1: drive immediately, e.g. in a done cycle), optionally
    // poke op_valid_i or flush at a given cycle after the accept edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input int poke_at, input bit now);
        int lat;
        int busy_n;
        if (!now) begin
            @(posedge clk_i);
            #1;
        end
        op_valid_i = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        @(posedge clk_i);
        #1;
        op_valid_i = 1'b0;
        op_i = 2'($urandom);
        a_i = $urandom;
        b_i = $urandom;
        lat = 0;
        busy_n = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == poke_at) op_valid_i = 1'b1;
            if (c == flush_at) flush_i = 1'b1;
            @(negedge clk_i);
            if (flush_at != 0 && c == flush_at + 1) begin
                check("flush_busy_drop", {65'b0, busy_o}, 66'b0);
                lat = -1;
                break;
            end
            if (done_o) begin
                lat = c;
                break;
            end
            if (busy_o) busy_n++;
            @(posedge clk_i);
            #1;
            op_valid_i = 1'b0;
            flush_i = 1'b0;
        end
        if (flush_at == 0) begin
            check("done_latency", 66'(lat), 66'(W + 2));
            check("busy_cycles", 66'(busy_n), 66'(W + 1));
        end
    endtask

    initial begin
        logic [63:0] prior;
        int lat;
        rst_i = 1'b0;
        op_valid_i = 1'b0;
        op_i = 2'b00;
        a_i = '0;
        b_i = '0;
        flush_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_state", {busy_o, done_o, hi_o, lo_o}, 66'b0);
        #1 rst_i = 1'b1;

        check("model_pin_mult", {2'b0, ref_result(2'b01, 32'hFFFF_FFFD, 32'd5)},
              {2'b0, 64'hFFFF_FFFF_FFFF_FFF1});
        check("model_pin_div", {2'b0, ref_result(2'b11, 32'hFFFF_FFF9, 32'd2)},
              {2'b0, 64'hFFFF_FFFF_FFFF_FFFD});

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        check("multu_max", {2'b0, hi_o, lo_o}, {2'b0, 64'hFFFF_FFFE_0000_0001});
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
        check("mult_neg", {2'b0, hi_o, lo_o}, {2'b0, 64'hFFFF_FFFF_FFFF_FFF1});
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        check("div_neg", {2'b0, hi_o, lo_o}, {2'b0, 64'hFFFF_FFFF_FFFF_FFFD});
        run_op(2'b10, 32'd100, 32'd7, 0, 0, 0);
        check("divu_100_7", {2'b0, hi_o, lo_o}, {2'b0, 64'h0000_0002_0000_000E});
        run_op(2'b10, 32'd7, 32'd0, 0, 0, 0);
        check("divu_by_zero", {2'b0, hi_o, lo_o}, {2'b0, 64'h0000_0007_FFFF_FFFF});
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        check("div_overflow", {2'b0, hi_o, lo_o}, {2'b0, 64'h0000_0000_8000_0000});

        run_op(2'b01, 32'd7, 32'd9, 0, 5, 0);
        check("poke_ignored", {2'b0, hi_o, lo_o}, {2'b0, 64'h0000_0000_0000_003F});
        repeat (3) @(negedge clk_i);
        check("poke_no_second_op", {65'b0, busy_o}, 66'b0);

        prior = {hi_o, lo_o};
        run_op(2'b11, 32'd100, 32'd7, 10, 0, 0);
        repeat (40) @(negedge clk_i);
        check("flush_hold", {2'b0, hi_o, lo_o}, {2'b0, 64'h0000_0000_0000_003F});
        run_op(2'b10, 32'd1000, 32'd3, 0, 0, 0);
        check("after_flush", {2'b0, hi_o, lo_o}, {2'b0, 64'h0000_0001_0000_014D});

        run_op(2'b00, 32'd3, 32'd4, 0, 0, 1);
        check("back_to_back", {2'b0, hi_o, lo_o}, {2'b0, 64'h0000_0000_0000_000C});

        // Async reset in the middle of a calculation.
        run_op(2'b01, 32'd5, 32'd6, 0, 0, 0);
        @(posedge clk_i);
        #1;
        op_valid_i = 1'b1;
        op_i = 2'b01;
        a_i = 32'd11;
        b_i = 32'd13;
        @(posedge clk_i);
        #1 op_valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #3 rst_i = 1'b0;
        #1 check("async_reset", {busy_o, done_o, hi_o, lo_o}, 66'b0);
        op_valid_i = 1'b1;
        op_i = 2'b00;
        a_i = 32'd6;
        b_i = 32'd7;
        @(negedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1 op_valid_i = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk_i);
            if (done_o) begin
                lat = c;
                break;
            end
        end
        check("reset_release_latency", 66'(lat), 66'(W + 2));
        check("reset_release_result", {2'b0, hi_o, lo_o}, {2'b0, 64'd42});

        // Randomized traffic with occasional flushes and spurious issues.
        for (int i = 0; i < 150; i++) begin
            int mode;
            mode = $urandom_range(0, 7);
            run_op(2'($urandom), pick_operand(), pick_operand(),
                   (mode == 0) ? $urandom_range(1, W + 1) : 0,
                   (mode == 1) ? $urandom_range(1, W + 1) : 0,
                   bit'($urandom_range(0, 1)));
        end
        repeat (3) @(negedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
